// File: rtl/board_pkg.sv
// Shared constants and FSM encoding for the 2048 board selector.
package board_pkg;

    localparam int CELLS   = 16;
    localparam int CELL_W  = 4;
    localparam int BOARD_W = CELLS * CELL_W;

    // SHOW: displaying out_ch, nothing pending. PEND: a different channel is requested.
    typedef enum logic [0:0] {
        SHOW = 1'b0,
        PEND = 1'b1
    } board_state_e;

endpackage

// File: rtl/board_cell_diff.sv
// Per-cell comparator between the board currently shown and the board about to be loaded.
// Only built when BOARD_SEL_DIFF_EN is defined; without it the selector carries no comparator.
`ifdef BOARD_SEL_DIFF_EN
module board_cell_diff
    import board_pkg::*;
(
    input  logic [BOARD_W-1:0] i_old,
    input  logic [BOARD_W-1:0] i_new,
    output logic [CELLS-1:0]   o_diff
);

    // Bit i flags that cell i changes value.
    always_comb begin
        o_diff = '0;
        for (int i = 0; i < CELLS; i++) begin
            o_diff[i] = (i_old[i*CELL_W +: CELL_W] != i_new[i*CELL_W +: CELL_W]);
        end
    end

endmodule
`endif

// File: rtl/board_select_sync.sv
// Frame-synchronised N-channel selector for 2048 boards (cells + judge flags).
// Channel changes requested on i_mode take effect only on an unfrozen frame tick,
// so the display never changes mid-frame. All outputs are registered.
// Optional feature: define BOARD_SEL_DIFF_EN to produce a per-cell change mask on each load;
// otherwise o_diff_mask is tied to zero.
//
// Handshake: there is no valid/ready pair; i_frame_tick is a one-cycle strobe that is
// qualified by ~i_freeze, and o_sw_done is a one-cycle strobe raised exactly in the cycle
// o_num/o_out_ch take a new channel.
module board_select_sync
    import board_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int MODE_W = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_frame_tick,
    input  logic                      i_freeze,
    input  logic [MODE_W-1:0]         i_mode,
    input  logic [N_CH*BOARD_W-1:0]   i_num_in,
    input  logic [N_CH*CELLS-1:0]     i_judge_in,
    output logic [BOARD_W-1:0]        o_num,
    output logic [CELLS-1:0]          o_judge,
    output logic [MODE_W-1:0]         o_out_ch,
    output logic                      o_busy,
    output logic                      o_sw_done,
    output logic                      o_bad_mode,
    output logic [CELLS-1:0]          o_diff_mask,
    output board_state_e              o_state,
    output logic [MODE_W-1:0]         o_pend_ch
);

    board_state_e        r_state;
    board_state_e        w_state_next;
    logic [BOARD_W-1:0]  r_num;
    logic [CELLS-1:0]    r_judge;
    logic [MODE_W-1:0]   r_out_ch;
    logic [MODE_W-1:0]   r_pend_ch;
    logic                r_sw_done;
    logic                r_bad_mode;

    logic                w_mode_ok;
    logic [MODE_W-1:0]   w_tgt;
    logic                w_upd;
    logic                w_load;
    logic                w_switch;
    logic [BOARD_W-1:0]  w_sel_num;
    logic [CELLS-1:0]    w_sel_judge;

    // Resolve the requested channel; an out-of-range mode means "keep what is shown".
    always_comb begin
        w_mode_ok = ({1'b0, i_mode} < (MODE_W+1)'(N_CH));
        w_tgt     = w_mode_ok ? i_mode : r_out_ch;
        w_upd     = i_frame_tick & ~i_freeze;
    end

    // Extract the board and judge flags of the target channel.
    always_comb begin
        w_sel_num   = '0;
        w_sel_judge = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_tgt == MODE_W'(k)) begin
                w_sel_num   = i_num_in[k*BOARD_W +: BOARD_W];
                w_sel_judge = i_judge_in[k*CELLS +: CELLS];
            end
        end
    end

    // Next state and load decisions. On a tick the newest request is applied directly,
    // so a request that changed during PEND uses its latest value.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_switch     = 1'b0;
        case (r_state)
            SHOW: begin
                if (w_upd) begin
                    w_load   = 1'b1;
                    w_switch = (w_tgt != r_out_ch);
                end else if (w_tgt != r_out_ch) begin
                    w_state_next = PEND;
                end
            end
            PEND: begin
                if (w_upd) begin
                    w_load       = 1'b1;
                    w_switch     = (w_tgt != r_out_ch);
                    w_state_next = SHOW;
                end else if (w_tgt == r_out_ch) begin
                    w_state_next = SHOW;
                end
            end
            default: w_state_next = SHOW;
        endcase
    end

    // State register and pending-channel latch; pend_ch tracks the request while pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= SHOW;
            r_pend_ch <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == PEND) begin
                r_pend_ch <= w_tgt;
            end
        end
    end

    // Displayed board, channel and done strobe; they only move on a load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_num     <= '0;
            r_judge   <= '0;
            r_out_ch  <= '0;
            r_sw_done <= 1'b0;
        end else begin
            r_sw_done <= w_switch;
            if (w_load) begin
                r_num    <= w_sel_num;
                r_judge  <= w_sel_judge;
                r_out_ch <= w_tgt;
            end
        end
    end

    // Sticky illegal-mode flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bad_mode <= 1'b0;
        end else if (!w_mode_ok) begin
            r_bad_mode <= 1'b1;
        end
    end

`ifdef BOARD_SEL_DIFF_EN
    logic [CELLS-1:0] w_diff;
    logic [CELLS-1:0] r_diff;

    board_cell_diff u_cell_diff (
        .i_old  (r_num),
        .i_new  (w_sel_num),
        .o_diff (w_diff)
    );

    // Change mask lives for exactly the cycle the new board is shown.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_diff <= '0;
        end else begin
            r_diff <= w_load ? w_diff : '0;
        end
    end

    assign o_diff_mask = r_diff;
`else
    assign o_diff_mask = '0;
`endif

    assign o_num      = r_num;
    assign o_judge    = r_judge;
    assign o_out_ch   = r_out_ch;
    assign o_busy     = (r_state == PEND);
    assign o_sw_done  = r_sw_done;
    assign o_bad_mode = r_bad_mode;
    assign o_state    = r_state;
    assign o_pend_ch  = r_pend_ch;

endmodule
